// File: rtl/lcd1602_frame_driver.sv
// lcd1602_frame_driver: drives an HD44780-compatible LCD1602 over an 8-bit
// write-only bus. It runs the power-up and init command sequence, then
// repeatedly writes two 16-character rows from a per-frame snapshot. It also
// maps the two 4-bit scores to ASCII characters.
//
// Optional build macro: LCD_DIFF_REFRESH_EN
//   undefined : back-to-back continuous refresh (LOAD follows every frame)
//   defined   : after a frame the FSM parks in IDLE and only reloads when
//               row_1/row_2 differ from the last snapshot
//
// Bus timing: every byte takes two ticks. On tick A, lcd_rs and DATA_BUS are
// driven and lcd_en rises. On tick B, lcd_en falls. rs and data then stay
// stable until the next tick A, which gives setup and hold around the
// falling edge.

module lcd1602_frame_driver #(
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned PWRUP_TICKS    = 20,
    parameter int unsigned CLR_WAIT_TICKS = 2
) (
    input  logic         Sys_Clk,
    input  logic         Sys_Rst,
    input  logic [127:0] row_1,
    input  logic [127:0] row_2,
    input  logic [3:0]   Score_L,
    input  logic [3:0]   Score_R,
    output logic [7:0]   Score_L_Char,
    output logic [7:0]   Score_R_Char,
    output logic         lcd_en,
    output logic         lcd_rw,
    output logic         lcd_rs,
    output logic [7:0]   DATA_BUS,
    output logic         frame_done
);

    localparam int unsigned TICK_W   = $clog2(TICK_DIV);
    localparam int unsigned WAIT_MAX = (PWRUP_TICKS > CLR_WAIT_TICKS) ? PWRUP_TICKS : CLR_WAIT_TICKS;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 2);
    localparam int unsigned IDX_W    = 4;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [WAIT_W-1:0] PWRUP_LAST = WAIT_W'((PWRUP_TICKS > 0) ? PWRUP_TICKS - 1 : 0);
    localparam logic [WAIT_W-1:0] CLR_LAST   = WAIT_W'((CLR_WAIT_TICKS > 0) ? CLR_WAIT_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0]  INIT_LAST  = IDX_W'(3);
    localparam logic [IDX_W-1:0]  COL_LAST   = IDX_W'(15);

    localparam logic [3:0] S_PWRUP    = 4'd0;
    localparam logic [3:0] S_INIT     = 4'd1;
    localparam logic [3:0] S_CLR_WAIT = 4'd2;
    localparam logic [3:0] S_LOAD     = 4'd3;
    localparam logic [3:0] S_ADDR1    = 4'd4;
    localparam logic [3:0] S_ROW1     = 4'd5;
    localparam logic [3:0] S_ADDR2    = 4'd6;
    localparam logic [3:0] S_ROW2     = 4'd7;
`ifdef LCD_DIFF_REFRESH_EN
    localparam logic [3:0] S_IDLE     = 4'd8;
    localparam logic [3:0] S_AFTER_FRAME = S_IDLE;
`else
    localparam logic [3:0] S_AFTER_FRAME = S_LOAD;
`endif

    // Init sequence: 8-bit/2-line/5x8, display on, entry mode increment, clear
    localparam logic [7:0] CMD_FUNC  = 8'h38;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    logic [3:0]        r_state;
    logic              r_phase;
    logic [IDX_W-1:0]  r_idx;
    logic [WAIT_W-1:0] r_wait;
    logic              r_en;
    logic              r_rs;
    logic [7:0]        r_data;
    logic              r_done;
    logic [127:0]      r_row1;
    logic [127:0]      r_row2;

    logic [3:0]        w_state_nxt;
    logic              w_phase_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              w_en_nxt;
    logic              w_rs_nxt;
    logic [7:0]        w_data_nxt;
    logic              w_done_nxt;
    logic              w_load;

    logic              w_slot_rs;
    logic [7:0]        w_slot_byte;

`ifdef LCD_DIFF_REFRESH_EN
    logic              w_rows_diff;
    assign w_rows_diff = (row_1 != r_row1) || (row_2 != r_row2);
`endif

    // Map a 4-bit value to its hex ASCII digit
    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        if (v < 4'd10) begin
            return 8'h30 + {4'h0, v};
        end else begin
            return 8'h37 + {4'h0, v};
        end
    endfunction

    assign Score_L_Char = hex_ascii(Score_L);
    assign Score_R_Char = hex_ascii(Score_R);

    assign lcd_en     = r_en;
    assign lcd_rw     = 1'b0;
    assign lcd_rs     = r_rs;
    assign DATA_BUS   = r_data;
    assign frame_done = r_done;

    // Free-running bus tick prescaler
    always_ff @(posedge Sys_Clk or negedge Sys_Rst) begin
        if (!Sys_Rst) begin
            r_tick_cnt <= '0;
        end else if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    assign w_tick = (r_tick_cnt == TICK_LAST);

    // Byte and register-select for the slot the FSM is currently in
    always_comb begin
        w_slot_rs   = 1'b0;
        w_slot_byte = 8'h00;
        case (r_state)
            S_INIT: begin
                case (r_idx[1:0])
                    2'd0:    w_slot_byte = CMD_FUNC;
                    2'd1:    w_slot_byte = CMD_DISP;
                    2'd2:    w_slot_byte = CMD_ENTRY;
                    default: w_slot_byte = CMD_CLEAR;
                endcase
            end
            S_ADDR1: w_slot_byte = CMD_LINE1;
            S_ADDR2: w_slot_byte = CMD_LINE2;
            S_ROW1: begin
                w_slot_rs   = 1'b1;
                w_slot_byte = r_row1[{~r_idx, 3'b000} +: 8];
            end
            S_ROW2: begin
                w_slot_rs   = 1'b1;
                w_slot_byte = r_row2[{~r_idx, 3'b000} +: 8];
            end
            default: begin
                w_slot_rs   = 1'b0;
                w_slot_byte = 8'h00;
            end
        endcase
    end

    // Next-state and next-output logic; everything advances only on ticks
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_idx_nxt   = r_idx;
        w_wait_nxt  = r_wait;
        w_en_nxt    = r_en;
        w_rs_nxt    = r_rs;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;

        if (w_tick) begin
            case (r_state)
                S_PWRUP: begin
                    if (r_wait == PWRUP_LAST) begin
                        w_wait_nxt  = '0;
                        w_idx_nxt   = '0;
                        w_phase_nxt = 1'b0;
                        w_state_nxt = S_INIT;
                    end else begin
                        w_wait_nxt = r_wait + WAIT_W'(1);
                    end
                end

                S_INIT, S_ADDR1, S_ROW1, S_ADDR2, S_ROW2: begin
                    if (!r_phase) begin
                        w_en_nxt    = 1'b1;
                        w_rs_nxt    = w_slot_rs;
                        w_data_nxt  = w_slot_byte;
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_en_nxt    = 1'b0;
                        w_phase_nxt = 1'b0;
                        case (r_state)
                            S_INIT: begin
                                if (r_idx == INIT_LAST) begin
                                    w_idx_nxt   = '0;
                                    w_wait_nxt  = '0;
                                    w_state_nxt = (CLR_WAIT_TICKS > 0) ? S_CLR_WAIT : S_LOAD;
                                end else begin
                                    w_idx_nxt = r_idx + IDX_W'(1);
                                end
                            end
                            S_ADDR1: begin
                                w_idx_nxt   = '0;
                                w_state_nxt = S_ROW1;
                            end
                            S_ROW1: begin
                                if (r_idx == COL_LAST) begin
                                    w_idx_nxt   = '0;
                                    w_state_nxt = S_ADDR2;
                                end else begin
                                    w_idx_nxt = r_idx + IDX_W'(1);
                                end
                            end
                            S_ADDR2: begin
                                w_idx_nxt   = '0;
                                w_state_nxt = S_ROW2;
                            end
                            default: begin
                                if (r_idx == COL_LAST) begin
                                    w_idx_nxt   = '0;
                                    w_done_nxt  = 1'b1;
                                    w_state_nxt = S_AFTER_FRAME;
                                end else begin
                                    w_idx_nxt = r_idx + IDX_W'(1);
                                end
                            end
                        endcase
                    end
                end

                S_CLR_WAIT: begin
                    if (r_wait == CLR_LAST) begin
                        w_wait_nxt  = '0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_wait_nxt = r_wait + WAIT_W'(1);
                    end
                end

                S_LOAD: begin
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_phase_nxt = 1'b0;
                    w_state_nxt = S_ADDR1;
                end

`ifdef LCD_DIFF_REFRESH_EN
                S_IDLE: begin
                    if (w_rows_diff) begin
                        w_state_nxt = S_LOAD;
                    end
                end
`endif

                default: begin
                    w_state_nxt = S_PWRUP;
                    w_wait_nxt  = '0;
                    w_idx_nxt   = '0;
                    w_phase_nxt = 1'b0;
                    w_en_nxt    = 1'b0;
                end
            endcase
        end
    end

    // State, bus output and row snapshot registers
    always_ff @(posedge Sys_Clk or negedge Sys_Rst) begin
        if (!Sys_Rst) begin
            r_state <= S_PWRUP;
            r_phase <= 1'b0;
            r_idx   <= '0;
            r_wait  <= '0;
            r_en    <= 1'b0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_done  <= 1'b0;
            r_row1  <= '0;
            r_row2  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_idx   <= w_idx_nxt;
            r_wait  <= w_wait_nxt;
            r_en    <= w_en_nxt;
            r_rs    <= w_rs_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_row1 <= row_1;
                r_row2 <= row_2;
            end
        end
    end

endmodule

// File: tb/tb_lcd1602_frame_driver.sv
// Testbench for lcd1602_frame_driver (default build, continuous refresh).
// A scoreboard holds the byte stream the LCD should latch. Each entry is a
// byte, its rs value and its position in the frame. A monitor pops one entry
// on every lcd_en falling edge and compares it with the bus.

module tb_lcd1602_frame_driver;

    localparam int unsigned TICK_DIV       = 4;
    localparam int unsigned PWRUP_TICKS    = 3;
    localparam int unsigned CLR_WAIT_TICKS = 2;
    localparam int          FIRST_EN_CYC   = (PWRUP_TICKS + 1) * TICK_DIV;
    localparam int          WAIT_LIMIT     = 2000;

    logic         Sys_Clk;
    logic         Sys_Rst;
    logic [127:0] row_1;
    logic [127:0] row_2;
    logic [3:0]   Score_L;
    logic [3:0]   Score_R;
    logic [7:0]   Score_L_Char;
    logic [7:0]   Score_R_Char;
    logic         lcd_en;
    logic         lcd_rw;
    logic         lcd_rs;
    logic [7:0]   DATA_BUS;
    logic         frame_done;

    lcd1602_frame_driver #(
        .TICK_DIV       (TICK_DIV),
        .PWRUP_TICKS    (PWRUP_TICKS),
        .CLR_WAIT_TICKS (CLR_WAIT_TICKS)
    ) dut (
        .Sys_Clk      (Sys_Clk),
        .Sys_Rst      (Sys_Rst),
        .row_1        (row_1),
        .row_2        (row_2),
        .Score_L      (Score_L),
        .Score_R      (Score_R),
        .Score_L_Char (Score_L_Char),
        .Score_R_Char (Score_R_Char),
        .lcd_en       (lcd_en),
        .lcd_rw       (lcd_rw),
        .lcd_rs       (lcd_rs),
        .DATA_BUS     (DATA_BUS),
        .frame_done   (frame_done)
    );

    initial Sys_Clk = 1'b0;
    always #5 Sys_Clk = ~Sys_Clk;

    int vectors;
    int miscompares;

    logic [7:0] exp_data[$];
    logic       exp_rs[$];
    int         exp_pos[$];

    int   cyc;
    int   rise_cyc;
    int   frames;
    int   byte_in_frame;
    int   done_pulses;
    logic prev_en;

    // Single comparison point for the whole bench
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic rs, input int pos);
        exp_data.push_back(d);
        exp_rs.push_back(rs);
        exp_pos.push_back(pos);
    endtask

    task automatic push_init();
        push_byte(8'h38, 1'b0, -1);
        push_byte(8'h0C, 1'b0, -1);
        push_byte(8'h06, 1'b0, -1);
        push_byte(8'h01, 1'b0, -1);
    endtask

    // A frame: line-1 address, 16 chars, line-2 address, 16 chars (pos 0..33)
    task automatic push_frame(input logic [127:0] r1, input logic [127:0] r2);
        push_byte(8'h80, 1'b0, 0);
        for (int c = 0; c < 16; c++) push_byte(r1[8*(15-c) +: 8], 1'b1, 1 + c);
        push_byte(8'hC0, 1'b0, 17);
        for (int c = 0; c < 16; c++) push_byte(r2[8*(15-c) +: 8], 1'b1, 18 + c);
    endtask

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = 8'($urandom_range(32, 126));
        return r;
    endfunction

    function automatic logic [7:0] score_ref(input int v);
        if (v <= 9) return 8'(48 + v);   // '0'..'9'
        return 8'(65 + (v - 10));        // 'A'..'F'
    endfunction

    // Cycles since reset release
    always @(posedge Sys_Clk or negedge Sys_Rst) begin
        if (!Sys_Rst) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Bus monitor: one scoreboard entry per lcd_en falling edge
    always @(negedge Sys_Clk) begin
        if (!Sys_Rst) begin
            prev_en       = 1'b0;
            byte_in_frame = 0;
        end else begin
            if (frame_done) done_pulses++;
            if (lcd_en && !prev_en && rise_cyc == 0) rise_cyc = cyc;
            if (!lcd_en && prev_en) begin
                if (exp_data.size() == 0) begin
                    check_val("sb_underflow", 32'(DATA_BUS), 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] d;
                    logic       rs;
                    int         pos;
                    d   = exp_data.pop_front();
                    rs  = exp_rs.pop_front();
                    pos = exp_pos.pop_front();
                    check_val("data_bus", 32'(DATA_BUS), 32'(d));
                    check_val("lcd_rs", 32'(lcd_rs), 32'(rs));
                    check_val("lcd_rw", 32'(lcd_rw), 32'd0);
                    check_val("frame_done", 32'(frame_done), 32'(pos == 33));
                    if (pos == 33) begin
                        frames++;
                        byte_in_frame = 0;
                    end else if (pos >= 0) begin
                        byte_in_frame = pos + 1;
                    end
                end
            end
            prev_en = lcd_en;
        end
    end

    initial begin
        vectors       = 0;
        miscompares   = 0;
        frames        = 0;
        done_pulses   = 0;
        rise_cyc      = 0;
        byte_in_frame = 0;
        prev_en       = 1'b0;
        Sys_Rst       = 1'b0;
        row_1         = "Welcome!        ";
        row_2         = "Two Players Mode";
        Score_L       = 4'd0;
        Score_R       = 4'd0;

        repeat (3) @(negedge Sys_Clk);
        check_val("rst_en",   32'(lcd_en),     32'd0);
        check_val("rst_rw",   32'(lcd_rw),     32'd0);
        check_val("rst_rs",   32'(lcd_rs),     32'd0);
        check_val("rst_data", 32'(DATA_BUS),   32'd0);
        check_val("rst_done", 32'(frame_done), 32'd0);

        // Score characters are combinational
        Score_L = 4'd3;
        Score_R = 4'd12;
        #1;
        check_val("score_l_3",  32'(Score_L_Char), 32'h33);
        check_val("score_r_12", 32'(Score_R_Char), 32'h43);
        for (int i = 0; i < 16; i++) begin
            int l;
            int r;
            l = int'($urandom_range(0, 15));
            r = int'($urandom_range(0, 15));
            Score_L = 4'(l);
            Score_R = 4'(r);
            #1;
            check_val("score_l", 32'(Score_L_Char), 32'(score_ref(l)));
            check_val("score_r", 32'(Score_R_Char), 32'(score_ref(r)));
        end

        push_init();
        push_frame(row_1, row_2);
        @(negedge Sys_Clk);
        Sys_Rst = 1'b1;

        // Frame 0: change row_1 while column 5 of line 1 is pending
        for (int i = 0; i < WAIT_LIMIT && !(frames == 0 && byte_in_frame == 6); i++) @(negedge Sys_Clk);
        check_val("wait_f0_col5", 32'(byte_in_frame), 32'd6);
        check_val("first_en_cycle", 32'(rise_cyc), 32'(FIRST_EN_CYC));
        row_1 = "Please Choose   ";
        push_frame(row_1, row_2);

        // Frames 1..4: random new text at a random point mid-frame
        for (int f = 1; f <= 4; f++) begin
            int k;
            k = int'($urandom_range(1, 32));
            for (int i = 0; i < WAIT_LIMIT && !(frames == f && byte_in_frame == k); i++) @(negedge Sys_Clk);
            check_val("wait_mid_frame", 32'(byte_in_frame), 32'(k));
            row_1 = rand_row();
            row_2 = rand_row();
            push_frame(row_1, row_2);
        end

        // Frame 5: reset during line 2, then full power-up again
        for (int i = 0; i < WAIT_LIMIT && !(frames == 5 && byte_in_frame == 22); i++) @(negedge Sys_Clk);
        check_val("wait_row2", 32'(byte_in_frame), 32'd22);
        @(posedge Sys_Clk);
        #2;
        Sys_Rst = 1'b0;
        #1;
        check_val("mid_rst_en",   32'(lcd_en),     32'd0);
        check_val("mid_rst_rs",   32'(lcd_rs),     32'd0);
        check_val("mid_rst_data", 32'(DATA_BUS),   32'd0);
        check_val("mid_rst_done", 32'(frame_done), 32'd0);
        exp_data.delete();
        exp_rs.delete();
        exp_pos.delete();
        rise_cyc = 0;
        push_init();
        push_frame(row_1, row_2);
        repeat (3) @(negedge Sys_Clk);
        Sys_Rst = 1'b1;

        for (int i = 0; i < WAIT_LIMIT && frames != 6; i++) @(negedge Sys_Clk);
        check_val("frames_after_rst", 32'(frames), 32'd6);
        check_val("first_en_after_rst", 32'(rise_cyc), 32'(FIRST_EN_CYC));
        repeat (2) @(negedge Sys_Clk);
        check_val("sb_empty", 32'(exp_data.size()), 32'd0);
        check_val("done_pulses", 32'(done_pulses), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lcd1602_frame_driver.md
Name: lcd1602_frame_driver

Overview:
Downstream display stage of the game controller. Takes the two 16-character text rows produced by the game state machine and drives an HD44780-compatible LCD1602 over an 8-bit, write-only bus. It performs the power-up/init command sequence, then repeatedly writes full frames. It also supplies the ASCII score characters the controller splices into row 2.

Parameters:
TICK_DIV, 50000, Sys_Clk cycles per bus tick (1 ms at 50 MHz); minimum 2.
PWRUP_TICKS, 20, ticks held idle after reset before the first command.
CLR_WAIT_TICKS, 2, extra idle ticks after the clear-display command.

Ports:
Sys_Clk  in  1  system clock (50 MHz).
Sys_Rst  in  1  asynchronous reset, active-low.
row_1  in  128  line 1 text; [127:120] is column 0, [7:0] is column 15.
row_2  in  128  line 2 text; same packing as row_1.
Score_L  in  4  left score.
Score_R  in  4  right score.
Score_L_Char  out  8  ASCII character for Score_L.
Score_R_Char  out  8  ASCII character for Score_R.
lcd_en  out  1  LCD enable strobe; LCD latches on the falling edge.
lcd_rw  out  1  constant 0 (write only).
lcd_rs  out  1  0 = command, 1 = data.
DATA_BUS  out  8  LCD data/command byte.
frame_done  out  1  one-cycle pulse after the last byte of a frame.

Behaviour:
- Reset: all outputs 0 (lcd_en, lcd_rw, lcd_rs, DATA_BUS, frame_done); tick counter 0; FSM returns to PWRUP.
- Reset asserted mid-frame: abort immediately; full power-up and init sequence repeats after release.
- Tick generation:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick is high for one cycle when the counter equals TICK_DIV-1.
  - All FSM actions happen only on tick cycles.
- Byte slot: 2 ticks per byte.
  - Tick A: drive lcd_rs and DATA_BUS, set lcd_en=1.
  - Tick B: set lcd_en=0.
  - lcd_rs and DATA_BUS hold through the next tick A (setup and hold around the falling edge).
- FSM states:
  - PWRUP: wait PWRUP_TICKS ticks, then go to INIT.
  - INIT: command slots in order 0x38, 0x0C, 0x06, 0x01.
  - CLR_WAIT: CLR_WAIT_TICKS ticks, then go to LOAD.
  - LOAD: on a tick, snapshot row_1 and row_2 into internal registers. A frame never mixes old and new text; input changes mid-frame appear only in the next frame.
  - ADDR1: command 0x80.
  - ROW1: 16 data slots, column 0 first.
  - ADDR2: command 0xC0.
  - ROW2: 16 data slots.
  - After ROW2: frame_done pulses on the tick B of the final slot, then go to LOAD.
- Frame length: 34 slots = 68 ticks, plus 1 LOAD tick.
- Score characters (combinational, no latency):
  - value 0..9 maps to 0x30+value.
  - value 10..15 maps to 0x41..0x46 ('A'..'F').

Optional Feature:
Macro LCD_DIFF_REFRESH_EN.
- Defined: after frame_done, the FSM goes to IDLE instead of LOAD. IDLE compares row_1/row_2 against the snapshot every cycle. On any difference, it moves to LOAD on the next tick. With unchanged inputs the bus stays quiet: lcd_en=0, DATA_BUS holds its last value.
- Undefined: continuous back-to-back refresh as described above; the IDLE state does not exist.

Test Plan:
1. TICK_DIV=4, PWRUP_TICKS=3, CLR_WAIT_TICKS=2, release reset -> no lcd_en pulse for the first 12 clocks; first slot is lcd_rs=0, DATA_BUS=0x38; bytes follow as 0x0C, 0x06, 0x01, 0x80.
2. row_1="Welcome!        ", row_2="Two Players Mode" -> monitor captures 34 bytes on lcd_en falling edges: 0x80, 'W'..' ', 0xC0, 'T'..'e'; lcd_rs=1 only on the 32 characters; frame_done pulses once; lcd_rw is 0 throughout.
3. Change row_1 to "Please Choose   " during ROW1 column 5 -> current frame finishes with "Welcome!" bytes; next frame carries "Please Choose".
4. Score_L=3, Score_R=12 -> Score_L_Char=0x33, Score_R_Char=0x43 in the same cycle.
5. Assert Sys_Rst low during ROW2 -> all outputs 0 asynchronously; after release, the PWRUP wait and 0x38 appear again.
6. LCD_DIFF_REFRESH_EN defined, static rows -> after the first frame_done there are no lcd_en edges for 500 clocks. Change row_2 -> a new frame starts within TICK_DIV+1 clocks.
